// File: rtl/keypad_lock_ctrl.sv
`default_nettype none
// ============================================================================
// keypad_lock_ctrl : keypad combination lock with password change, lockout
//                    countdown and pattern-sequenced buzzer
// Revision 1.0
// ============================================================================
module keypad_lock_ctrl #(
  parameter int                  DIGITS    = 3,
  parameter logic [4*DIGITS-1:0] PASSWORD  = 12'h246,
  parameter int                  MAX_TRIES = 3,
  parameter int                  LOCK_SEC  = 20,
  parameter int                  CLK_HZ    = 50_000_000,
  parameter int                  TONE_KEY  = 50_000,
  parameter int                  TONE_OK   = 25_000,
  parameter int                  TONE_FAIL = 100_000
) (
  input  logic                         clk,
  input  logic                         RSTn,
  input  logic [15:0]                  onehot,
  output logic [4*DIGITS-1:0]          binary,
  output logic [$clog2(DIGITS+1)-1:0]  times,
  output logic [3:0]                   tries,
  output logic                         unlocked,
  output logic                         locked_out,
  output logic                         buzzer
);

  localparam int NW      = 4 * DIGITS;
  localparam int TW      = $clog2(DIGITS + 1);
  localparam int SW      = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int PW      = $clog2(3 * CLK_HZ / 5 + 2);
  localparam int TMAX_KO = (TONE_KEY > TONE_OK) ? TONE_KEY : TONE_OK;
  localparam int TMAX    = (TMAX_KO > TONE_FAIL) ? TMAX_KO : TONE_FAIL;
  localparam int HW      = $clog2(TMAX + 1);

  localparam logic [TW-1:0] TIMES_FULL = TW'(DIGITS);
  localparam logic [3:0]    TRIES_MAX  = 4'(MAX_TRIES);
  localparam logic [6:0]    LOCK_SEC_C = 7'(LOCK_SEC);
  localparam logic [SW-1:0] TICK_LAST  = SW'(CLK_HZ - 1);
  localparam logic [PW-1:0] DUR_KEY    = PW'(CLK_HZ / 5);
  localparam logic [PW-1:0] DUR_OK     = PW'(3 * CLK_HZ / 5);
  localparam logic [PW-1:0] SEG_FAIL   = PW'(CLK_HZ / 10);
  localparam logic [PW-1:0] SEG2_FAIL  = PW'(2 * (CLK_HZ / 10));
  localparam logic [PW-1:0] DUR_FAIL   = PW'(3 * (CLK_HZ / 10));
  localparam logic [NW-1:0] BLANK      = '1;
  localparam logic [31:0]   PASS_W     = 32'hFFFF_FA55;
  localparam logic [NW-1:0] PASS_DISP  = PASS_W[NW-1:0];

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_SETPW   = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    PAT_IDLE = 2'd0,
    PAT_KEY  = 2'd1,
    PAT_OK   = 2'd2,
    PAT_FAIL = 2'd3
  } pat_t;

  function automatic logic [NW-1:0] bcd_disp(input logic [6:0] v);
    logic [31:0] w;
    w      = 32'h0;
    w[7:4] = 4'(v / 7'd10);
    w[3:0] = 4'(v % 7'd10);
    return w[NW-1:0];
  endfunction

  function automatic logic [HW-1:0] half_period_m1(input pat_t p);
    logic [HW-1:0] r;
    case (p)
      PAT_KEY:  r = HW'(TONE_KEY - 1);
      PAT_OK:   r = HW'(TONE_OK - 1);
      PAT_FAIL: r = HW'(TONE_FAIL - 1);
      default:  r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [PW-1:0] pat_duration(input pat_t p);
    logic [PW-1:0] r;
    case (p)
      PAT_KEY:  r = DUR_KEY;
      PAT_OK:   r = DUR_OK;
      PAT_FAIL: r = DUR_FAIL;
      default:  r = '0;
    endcase
    return r;
  endfunction

  logic [15:0]   key_q, key_d, prev_key_q, prev_key_d;
  state_t        state_q, state_d;
  logic [NW-1:0] binary_q, binary_d, pw_q, pw_d;
  logic [TW-1:0] times_q, times_d;
  logic [3:0]    tries_q, tries_d, tries_inc;
  logic [6:0]    sec_q, sec_d;
  logic [SW-1:0] tick_q, tick_d;
  pat_t          pat_q, pat_d, start_pat;
  logic [PW-1:0] pcnt_q, pcnt_d, pcnt_inc;
  logic [HW-1:0] tone_q, tone_d, half_m1;
  logic          buzz_q, buzz_d;
  logic          start;

  logic          is_digit, is_enter, is_clear, is_admin, is_set, is_lock;
  logic [3:0]    digit;
  logic          press_ok, ev_digit, ev_enter, ev_clear, ev_admin, ev_set, ev_lock;
  logic          full, tick;

  // Only the fifteen mapped codes decode; everything else (incl. 0x0010) is inert.
  always_comb begin
    is_digit = 1'b0;
    is_enter = 1'b0;
    is_clear = 1'b0;
    is_admin = 1'b0;
    is_set   = 1'b0;
    is_lock  = 1'b0;
    digit    = 4'd0;
    case (key_q)
      16'h0008: begin is_digit = 1'b1; digit = 4'd0; end
      16'h0080: begin is_digit = 1'b1; digit = 4'd1; end
      16'h0040: begin is_digit = 1'b1; digit = 4'd2; end
      16'h0020: begin is_digit = 1'b1; digit = 4'd3; end
      16'h0800: begin is_digit = 1'b1; digit = 4'd4; end
      16'h0400: begin is_digit = 1'b1; digit = 4'd5; end
      16'h0200: begin is_digit = 1'b1; digit = 4'd6; end
      16'h8000: begin is_digit = 1'b1; digit = 4'd7; end
      16'h4000: begin is_digit = 1'b1; digit = 4'd8; end
      16'h2000: begin is_digit = 1'b1; digit = 4'd9; end
      16'h0001: is_enter = 1'b1;
      16'h1000: is_clear = 1'b1;
      16'h0100: is_admin = 1'b1;
      16'h0002: is_set   = 1'b1;
      16'h0004: is_lock  = 1'b1;
      default:  ;
    endcase
  end

  assign press_ok = (prev_key_q == 16'h0);
  assign ev_digit = press_ok & is_digit;
  assign ev_enter = press_ok & is_enter;
  assign ev_clear = press_ok & is_clear;
  assign ev_admin = press_ok & is_admin;
  assign ev_set   = press_ok & is_set;
  assign ev_lock  = press_ok & is_lock;
  assign full     = (times_q == TIMES_FULL);
  assign tick     = (tick_q == TICK_LAST);

  always_comb begin
    key_d      = onehot;
    prev_key_d = key_q;
    state_d    = state_q;
    binary_d   = binary_q;
    pw_d       = pw_q;
    times_d    = times_q;
    tries_d    = tries_q;
    sec_d      = sec_q;
    tick_d     = tick ? '0 : tick_q + 1'b1;
    tries_inc  = tries_q + 4'd1;
    start      = 1'b0;
    start_pat  = PAT_IDLE;

    if (ev_admin) begin
      state_d  = ST_ENTRY;
      tries_d  = 4'd0;
      binary_d = BLANK;
      times_d  = '0;
    end else begin
      case (state_q)
        ST_ENTRY: begin
          if (ev_digit && !full) begin
            binary_d      = binary_q << 4;
            binary_d[3:0] = digit;
            times_d       = times_q + 1'b1;
            start         = 1'b1;
            start_pat     = PAT_KEY;
          end else if (ev_enter && full) begin
            start = 1'b1;
            if (binary_q == pw_q) begin
              state_d   = ST_OPEN;
              binary_d  = PASS_DISP;
              tries_d   = 4'd0;
              start_pat = PAT_OK;
            end else begin
              tries_d   = tries_inc;
              binary_d  = BLANK;
              times_d   = '0;
              start_pat = PAT_FAIL;
              if (tries_inc == TRIES_MAX) begin
                state_d  = ST_LOCKOUT;
                sec_d    = LOCK_SEC_C;
                tick_d   = '0;
                binary_d = bcd_disp(LOCK_SEC_C);
              end
            end
          end else if (ev_clear) begin
            binary_d = BLANK;
            times_d  = '0;
          end
        end
        ST_OPEN: begin
          if (ev_lock) begin
            state_d  = ST_ENTRY;
            binary_d = BLANK;
            times_d  = '0;
          end else if (ev_set) begin
            state_d  = ST_SETPW;
            binary_d = BLANK;
            times_d  = '0;
          end
        end
        ST_SETPW: begin
          if (ev_digit && !full) begin
            binary_d      = binary_q << 4;
            binary_d[3:0] = digit;
            times_d       = times_q + 1'b1;
            start         = 1'b1;
            start_pat     = PAT_KEY;
          end else if (ev_enter && full) begin
            pw_d      = binary_q;
            state_d   = ST_ENTRY;
            binary_d  = BLANK;
            times_d   = '0;
            start     = 1'b1;
            start_pat = PAT_OK;
          end else if (ev_clear) begin
            state_d  = ST_OPEN;
            binary_d = PASS_DISP;
            times_d  = '0;
          end
        end
        ST_LOCKOUT: begin
          if (tick) begin
            if (sec_q == 7'd0) begin
              state_d  = ST_ENTRY;
              tries_d  = 4'd0;
              binary_d = BLANK;
              times_d  = '0;
            end else begin
              sec_d    = sec_q - 7'd1;
              binary_d = bcd_disp(sec_q - 7'd1);
            end
          end
        end
        default: state_d = ST_ENTRY;
      endcase
    end
  end

  // Tone counter is preloaded to its wrap value so the first active cycle toggles high.
  always_comb begin
    pat_d    = pat_q;
    pcnt_d   = pcnt_q;
    tone_d   = tone_q;
    buzz_d   = buzz_q;
    pcnt_inc = pcnt_q + 1'b1;
    half_m1  = half_period_m1(pat_q);
    if (start) begin
      pat_d  = start_pat;
      pcnt_d = '0;
      tone_d = half_period_m1(start_pat);
      buzz_d = 1'b0;
    end else if (pat_q != PAT_IDLE) begin
      if (pcnt_q == pat_duration(pat_q)) begin
        pat_d  = PAT_IDLE;
        pcnt_d = '0;
        tone_d = '0;
        buzz_d = 1'b0;
      end else begin
        pcnt_d = pcnt_inc;
        if (pat_q == PAT_FAIL && pcnt_inc > SEG_FAIL && pcnt_inc <= SEG2_FAIL) begin
          buzz_d = 1'b0;
          tone_d = half_m1;
        end else if (tone_q == half_m1) begin
          tone_d = '0;
          buzz_d = ~buzz_q;
        end else begin
          tone_d = tone_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!RSTn) begin
      key_q      <= 16'h0;
      prev_key_q <= 16'h0;
      state_q    <= ST_ENTRY;
      binary_q   <= BLANK;
      pw_q       <= PASSWORD;
      times_q    <= '0;
      tries_q    <= 4'd0;
      sec_q      <= 7'd0;
      tick_q     <= '0;
      pat_q      <= PAT_IDLE;
      pcnt_q     <= '0;
      tone_q     <= '0;
      buzz_q     <= 1'b0;
    end else begin
      key_q      <= key_d;
      prev_key_q <= prev_key_d;
      state_q    <= state_d;
      binary_q   <= binary_d;
      pw_q       <= pw_d;
      times_q    <= times_d;
      tries_q    <= tries_d;
      sec_q      <= sec_d;
      tick_q     <= tick_d;
      pat_q      <= pat_d;
      pcnt_q     <= pcnt_d;
      tone_q     <= tone_d;
      buzz_q     <= buzz_d;
    end
  end

  assign binary     = binary_q;
  assign times      = times_q;
  assign tries      = tries_q;
  assign unlocked   = (state_q == ST_OPEN);
  assign locked_out = (state_q == ST_LOCKOUT);
  assign buzzer     = buzz_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_lock_ctrl.sv
`default_nettype none
// ============================================================================
// tb_keypad_lock_ctrl : scoreboard bench for keypad_lock_ctrl
// Revision 1.0
// ============================================================================
module tb_keypad_lock_ctrl;

  localparam logic [15:0] K_ENTER = 16'h0001;
  localparam logic [15:0] K_CLEAR = 16'h1000;
  localparam logic [15:0] K_ADMIN = 16'h0100;
  localparam logic [15:0] K_SET   = 16'h0002;
  localparam logic [15:0] K_LOCK  = 16'h0004;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] onehot = 16'h0;
  logic [11:0] binary;
  logic [1:0]  times;
  logic [3:0]  tries;
  logic        unlocked, locked_out, buzzer;
  logic [19:0] status;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hi_total = 0;
  int rise_total = 0;
  logic buz_prev = 1'b0;
  logic mon_en = 1'b0;

  logic [19:0] exp_q[$];
  string       name_q[$];

  keypad_lock_ctrl #(
    .DIGITS(3), .PASSWORD(12'h246), .MAX_TRIES(3), .LOCK_SEC(3),
    .CLK_HZ(1000), .TONE_KEY(5), .TONE_OK(5), .TONE_FAIL(5)
  ) dut (
    .clk(clk), .RSTn(rst_n), .onehot(onehot), .binary(binary), .times(times),
    .tries(tries), .unlocked(unlocked), .locked_out(locked_out), .buzzer(buzzer)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign status = {binary, times, tries, unlocked, locked_out};

  always @(posedge clk) begin
    #1;
    if (buzzer === 1'b1) hi_total++;
    if (buzzer === 1'b1 && buz_prev !== 1'b1) rise_total++;
    buz_prev = buzzer;
  end

  function automatic logic [15:0] dig(input int d);
    logic [15:0] c;
    case (d)
      0: c = 16'h0008; 1: c = 16'h0080; 2: c = 16'h0040; 3: c = 16'h0020;
      4: c = 16'h0800; 5: c = 16'h0400; 6: c = 16'h0200; 7: c = 16'h8000;
      8: c = 16'h4000; default: c = 16'h2000;
    endcase
    return c;
  endfunction

  task automatic push(input string nm, input logic [11:0] b, input logic [1:0] tm,
                      input logic [3:0] tr, input logic un, input logic lo);
    exp_q.push_back({b, tm, tr, un, lo});
    name_q.push_back(nm);
  endtask

  task automatic press(input logic [15:0] code, input int hold, input int gap);
    onehot = code;
    repeat (hold) @(negedge clk);
    onehot = 16'h0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check(input string nm, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, want);
    end
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check(nm, exp_q.size(), 0);
  endtask

  // Three digits with the display/times progression they must produce.
  task automatic enter3(input int a, input int b, input int c, input logic [3:0] tr);
    push("digit_a", {8'hFF, 4'(a)}, 2'd1, tr, 1'b0, 1'b0);
    press(dig(a), 3, 10);
    push("digit_b", {4'hF, 4'(a), 4'(b)}, 2'd2, tr, 1'b0, 1'b0);
    press(dig(b), 3, 10);
    push("digit_c", {4'(a), 4'(b), 4'(c)}, 2'd3, tr, 1'b0, 1'b0);
    press(dig(c), 3, 10);
  endtask

  // Monitor: every change of the observable status consumes one expectation.
  initial begin
    logic [19:0] last, cur, e;
    string nm;
    wait (mon_en);
    last = status;
    forever begin
      @(negedge clk);
      cur = status;
      if (cur !== last) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change: got bin=%h times=%0d tries=%0d unl=%b lo=%b, expected no change",
                   cur[19:8], cur[7:6], cur[5:2], cur[1], cur[0]);
        end else begin
          e  = exp_q.pop_front();
          nm = name_q.pop_front();
          if (cur !== e) begin
            n_fail++;
            $display("FAIL %s: got bin=%h times=%0d tries=%0d unl=%b lo=%b, expected bin=%h times=%0d tries=%0d unl=%b lo=%b",
                     nm, cur[19:8], cur[7:6], cur[5:2], cur[1], cur[0],
                     e[19:8], e[7:6], e[5:2], e[1], e[0]);
          end
        end
        last = cur;
      end
    end
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, r0, c0, t, d;

    repeat (3) @(negedge clk);
    check("reset_status", int'(status), int'(20'hFFF00));
    check("reset_buzzer", int'(buzzer), 0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);

    // Unlock with reset password, OK tone
    push("d2", 12'hFF2, 2'd1, 4'd0, 1'b0, 1'b0); press(dig(2), 3, 10);
    push("d4", 12'hF24, 2'd2, 4'd0, 1'b0, 1'b0); press(dig(4), 3, 10);
    push("d6", 12'h246, 2'd3, 4'd0, 1'b0, 1'b0); press(dig(6), 3, 250);
    h0 = hi_total; r0 = rise_total;
    push("unlock", 12'hA55, 2'd3, 4'd0, 1'b1, 1'b0); press(K_ENTER, 3, 700);
    check("ok_tone_high_cycles", hi_total - h0, 300);
    check("ok_tone_rises", rise_total - r0, 60);
    push("lock", 12'hFFF, 2'd0, 4'd0, 1'b0, 1'b0); press(K_LOCK, 3, 10);
    drain("drain_unlock");

    // Held key, short ENTER, saturation
    h0 = hi_total; r0 = rise_total;
    push("hold5", 12'hFF5, 2'd1, 4'd0, 1'b0, 1'b0); press(dig(5), 100, 250);
    check("key_tone_high_cycles", hi_total - h0, 100);
    check("key_tone_rises", rise_total - r0, 20);
    press(K_ENTER, 3, 10);
    push("d1", 12'hF51, 2'd2, 4'd0, 1'b0, 1'b0); press(dig(1), 3, 10);
    push("d2s", 12'h512, 2'd3, 4'd0, 1'b0, 1'b0); press(dig(2), 3, 250);
    h0 = hi_total;
    press(dig(3), 3, 250);
    check("saturated_digit_silent", hi_total - h0, 0);
    push("clear", 12'hFFF, 2'd0, 4'd0, 1'b0, 1'b0); press(K_CLEAR, 3, 10);
    drain("drain_hold");

    // Password change to 987
    enter3(2, 4, 6, 4'd0);
    push("unlock2", 12'hA55, 2'd3, 4'd0, 1'b1, 1'b0); press(K_ENTER, 3, 10);
    push("set", 12'hFFF, 2'd0, 4'd0, 1'b0, 1'b0); press(K_SET, 3, 10);
    enter3(9, 8, 7, 4'd0);
    push("setpw_done", 12'hFFF, 2'd0, 4'd0, 1'b0, 1'b0); press(K_ENTER, 3, 10);
    enter3(2, 4, 6, 4'd0);
    push("old_pw_fail", 12'hFFF, 2'd0, 4'd1, 1'b0, 1'b0); press(K_ENTER, 3, 10);
    enter3(9, 8, 7, 4'd1);
    push("new_pw_ok", 12'hA55, 2'd3, 4'd0, 1'b1, 1'b0); press(K_ENTER, 3, 10);
    push("lock3", 12'hFFF, 2'd0, 4'd0, 1'b0, 1'b0); press(K_LOCK, 3, 10);
    drain("drain_setpw");

    // Lockout via three failures, full countdown
    enter3(1, 1, 1, 4'd0);
    push("fail1", 12'hFFF, 2'd0, 4'd1, 1'b0, 1'b0); press(K_ENTER, 3, 10);
    enter3(1, 1, 1, 4'd1);
    push("fail2", 12'hFFF, 2'd0, 4'd2, 1'b0, 1'b0); press(K_ENTER, 3, 10);
    enter3(1, 1, 1, 4'd2);
    repeat (250) @(negedge clk);
    push("lockout3", 12'h003, 2'd0, 4'd3, 1'b0, 1'b1);
    push("lockout2", 12'h002, 2'd0, 4'd3, 1'b0, 1'b1);
    push("lockout1", 12'h001, 2'd0, 4'd3, 1'b0, 1'b1);
    push("lockout0", 12'h000, 2'd0, 4'd3, 1'b0, 1'b1);
    push("lockout_exit", 12'hFFF, 2'd0, 4'd0, 1'b0, 1'b0);
    h0 = hi_total; r0 = rise_total; c0 = cyc;
    press(K_ENTER, 3, 2);
    t = 0;
    while (binary !== 12'h002 && t < 1100) begin @(negedge clk); t++; end
    check("first_tick_latency", cyc - c0, 1002);
    check("fail_tone_high_cycles", hi_total - h0, 100);
    check("fail_tone_rises", rise_total - r0, 20);
    h0 = hi_total;
    press(dig(5), 3, 10); press(K_ENTER, 3, 10); press(K_CLEAR, 3, 10);
    press(K_SET, 3, 10); press(K_LOCK, 3, 10);
    check("lockout_keys_silent", hi_total - h0, 0);
    t = 0;
    while (locked_out !== 1'b0 && t < 5000) begin @(negedge clk); t++; end
    d = cyc - c0;
    n_tests++;
    if (d < 4000 || d > 4004) begin
      n_fail++;
      $display("FAIL lockout_duration: got %0d cycles, expected 4000..4004", d);
    end
    drain("drain_lockout");

    // Lockout cut short by ADMIN
    enter3(1, 1, 1, 4'd0);
    push("a_fail1", 12'hFFF, 2'd0, 4'd1, 1'b0, 1'b0); press(K_ENTER, 3, 10);
    enter3(1, 1, 1, 4'd1);
    push("a_fail2", 12'hFFF, 2'd0, 4'd2, 1'b0, 1'b0); press(K_ENTER, 3, 10);
    enter3(1, 1, 1, 4'd2);
    push("a_lockout", 12'h003, 2'd0, 4'd3, 1'b0, 1'b1); press(K_ENTER, 3, 100);
    push("admin", 12'hFFF, 2'd0, 4'd0, 1'b0, 1'b0); press(K_ADMIN, 3, 1500);
    drain("drain_admin");

    // Multi-hot code, then reset in the middle of a FAIL pattern
    press(16'h0041, 20, 10);
    enter3(1, 1, 1, 4'd0);
    push("pre_reset_fail", 12'hFFF, 2'd0, 4'd1, 1'b0, 1'b0); press(K_ENTER, 3, 0);
    t = 0;
    while (buzzer !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    check("fail_tone_active", int'(buzzer), 1);
    push("reset_mid_pattern", 12'hFFF, 2'd0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("reset_buzzer_mid", int'(buzzer), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    enter3(2, 4, 6, 4'd0);
    push("reset_pw_restored", 12'hA55, 2'd3, 4'd0, 1'b1, 1'b0); press(K_ENTER, 3, 10);
    drain("drain_reset");

    repeat (20) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
